// File: rtl/imm_encoder.sv
// Encodes a signed 64-bit immediate into a LEGv8 base word, or expands it into
// a MOVZ/MOVK load of a scratch register followed by the base word.
module imm_encoder #(
  parameter logic [4:0] SCRATCH_DEFAULT = 5'd9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_branch,
  input  logic [31:0] in_base,
  input  logic [63:0] in_imm,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, MOVZ, MOVK, BASE} state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [63:0] imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  hw_q, hw_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic        out_err_q, out_err_d;

  logic        adv, accept, fit_d, fit_cb;
  logic [2:0]  nh;

  // {found, hw}: lowest halfword above 'after' that is nonzero
  function automatic logic [2:0] next_hw(input logic [63:0] imm, input logic [1:0] after);
    logic [2:0] r;
    r = '0;
    for (int k = 3; k >= 1; k--)
      if (k > int'(after) && imm[16*k +: 16] != 16'd0) r = {1'b1, 2'(k)};
    return r;
  endfunction

  assign fit_d   = (&in_imm[63:8])  | ~(|in_imm[63:8]);
  assign fit_cb  = (&in_imm[63:18]) | ~(|in_imm[63:18]);
  assign adv     = !out_valid_q || out_ready;
  assign in_ready = (state_q == IDLE) && (!out_valid_q || (out_ready && out_last_q));
  assign accept  = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    hw_d        = hw_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    nh          = '0;
    if (adv) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_err_d   = 1'b0;
    end
    case (state_q)
      IDLE: if (accept) begin
        base_d = in_base;
        imm_d  = in_imm;
        rd_d   = in_rd_valid ? in_rd : SCRATCH_DEFAULT;
        if (in_branch) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          out_err_d   = !fit_cb;
          out_instr_d = {in_base[31:24], fit_cb ? in_imm[18:0] : 19'd0, in_base[4:0]};
        end else if (fit_d) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          out_instr_d = {in_base[31:21], in_imm[8:0], in_base[11:0]};
        end else begin
          state_d = MOVZ;
        end
      end
      MOVZ: if (adv) begin
        out_valid_d = 1'b1;
        out_instr_d = {9'b110100101, 2'b00, imm_q[15:0], rd_q};
        nh          = next_hw(imm_q, 2'd0);
        hw_d        = nh[1:0];
        state_d     = nh[2] ? MOVK : BASE;
      end
      MOVK: if (adv) begin
        out_valid_d = 1'b1;
        out_instr_d = {9'b111100101, hw_q, imm_q[{hw_q, 4'b0000} +: 16], rd_q};
        nh          = next_hw(imm_q, hw_q);
        hw_d        = nh[1:0];
        state_d     = nh[2] ? MOVK : BASE;
      end
      BASE: if (adv) begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_instr_d = {base_q[31:21], 9'd0, base_q[11:0]};
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      hw_q        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      hw_q        <= hw_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: expected words are queued at issue time
// and compared as the encoder hands them over.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_branch, in_rd_valid;
  logic        out_valid, out_ready, out_last, out_err;
  logic [31:0] in_base, out_instr;
  logic [63:0] in_imm;
  logic [4:0]  in_rd;

  typedef struct packed {logic [31:0] instr; logic last; logic err;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_branch(in_branch), .in_base(in_base), .in_imm(in_imm), .in_rd(in_rd),
    .in_rd_valid(in_rd_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last), .out_err(out_err)
  );

  task automatic expect_word(input logic [31:0] i, input logic l, input logic e);
    exp_t x;
    x.instr = i; x.last = l; x.err = e;
    q.push_back(x);
  endtask

  // Reference encoder written from the range definitions of each field
  task automatic model(input logic br, input logic [31:0] base, input logic [63:0] imm,
                       input logic [4:0] rd);
    longint s;
    s = longint'(imm);
    if (br) begin
      if (s >= -262144 && s <= 262143)
        expect_word((base & 32'hFF00001F) | (32'(imm[18:0]) << 5), 1'b1, 1'b0);
      else
        expect_word(base & 32'hFF00001F, 1'b1, 1'b1);
    end else if (s >= -256 && s <= 255) begin
      expect_word((base & 32'hFFE00FFF) | (32'(imm[8:0]) << 12), 1'b1, 1'b0);
    end else begin
      expect_word(32'hD2800000 | (32'(imm[15:0]) << 5) | 32'(rd), 1'b0, 1'b0);
      for (int h = 1; h < 4; h++)
        if (imm[16*h +: 16] != 16'd0)
          expect_word(32'hF2800000 | (32'(h) << 21) | (32'(imm[16*h +: 16]) << 5) | 32'(rd),
                      1'b0, 1'b0);
      expect_word(base & 32'hFFE00FFF, 1'b1, 1'b0);
    end
  endtask

  task automatic issue(input logic br, input logic [31:0] base, input logic [63:0] imm,
                       input logic [4:0] rd, input logic rdv);
    int i;
    i = 0;
    while (!in_ready && i < 20) begin @(negedge clk); i++; end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_branch = br; in_base = base; in_imm = imm;
    in_rd = rd; in_rd_valid = rdv;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Collect queued words; the first valid word is held off for 'stall' cycles
  task automatic drain(input int stall);
    int cyc;
    exp_t x;
    cyc = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && cyc < 40) begin
      if (out_valid) begin
        x = q[0];
        out_ready = (stall == 0);
        #1;
        n_chk++;
        if ({out_instr, out_last, out_err} !== {x.instr, x.last, x.err}) begin
          n_fail++;
          $display("FAIL word: got %h last=%b err=%b, required %h last=%b err=%b",
                   out_instr, out_last, out_err, x.instr, x.last, x.err);
        end
        n_chk++;
        if (in_ready !== (out_ready && x.last)) begin
          n_fail++;
          $display("FAIL in_ready_seq: got %b required %b", in_ready, out_ready && x.last);
        end
        if (out_ready) void'(q.pop_front());
        else stall--;
      end
      cyc++;
      @(negedge clk);
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout: %0d words outstanding, required 0", q.size());
    end
    q.delete();
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_branch = 1'b0;
    in_base = '0; in_imm = '0; in_rd = '0; in_rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({out_valid, out_last, out_err, out_instr, in_ready} !== {3'b000, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: valid=%b last=%b err=%b instr=%h ready=%b, required 0 0 0 0 1",
               out_valid, out_last, out_err, out_instr, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_d_fit;
    expect_word(32'hF85FD000, 1'b1, 1'b0);
    issue(1'b0, 32'hF8400000, 64'hFFFFFFFFFFFFFFFD, 5'd0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL d_fit_latency: out_valid=%b required 1", out_valid);
    end
    drain(0);
  endtask

  task automatic test_movk_seq(input int stall);
    expect_word(32'hD28000A9, 1'b0, 1'b0);
    expect_word(32'hF2C00029, 1'b0, 1'b0);
    expect_word(32'hF8400000, 1'b1, 1'b0);
    issue(1'b0, 32'hF8400000, 64'h0000000100000005, 5'd9, 1'b1);
    drain(stall);
  endtask

  task automatic test_cb;
    expect_word(32'hB4FFFFE0, 1'b1, 1'b0);
    issue(1'b1, 32'hB4000000, 64'hFFFFFFFFFFFFFFFF, 5'd0, 1'b0);
    drain(0);
    expect_word(32'hB4000000, 1'b1, 1'b1);
    issue(1'b1, 32'hB4000000, 64'h0000000000040000, 5'd0, 1'b0);
    drain(0);
  endtask

  task automatic test_skip_hw;
    expect_word(32'hD2800009, 1'b0, 1'b0);
    expect_word(32'hF2F00009, 1'b0, 1'b0);
    expect_word(32'hF8400000, 1'b1, 1'b0);
    issue(1'b0, 32'hF8400000, 64'h8000000000000000, 5'd3, 1'b0);
    drain(0);
  endtask

  task automatic test_reset_mid;
    int i;
    logic seen;
    issue(1'b0, 32'hF8400000, 64'h0000000100000005, 5'd9, 1'b1);
    i = 0;
    while (!out_valid && i < 10) begin @(negedge clk); i++; end
    n_chk++;
    if (out_instr !== 32'hD28000A9 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_movz: got %h valid=%b required d28000a9 1", out_instr, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_quiet: stray word seen=%b required 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int idx, cyc;
    exp_t x;
    idx = 0; cyc = 0;
    out_ready = 1'b1;
    while ((idx < 4 || q.size() > 0) && cyc < 30) begin
      if (out_valid && q.size() > 0) begin
        x = q.pop_front();
        n_chk++;
        if ({out_instr, out_last, out_err} !== {x.instr, x.last, x.err}) begin
          n_fail++;
          $display("FAIL b2b_word: got %h last=%b err=%b, required %h last=%b err=%b",
                   out_instr, out_last, out_err, x.instr, x.last, x.err);
        end
      end
      if (idx < 4 && in_ready) begin
        in_valid = 1'b1; in_branch = 1'b0; in_rd_valid = 1'b0;
        in_base = 32'hF8400000 | 32'(idx);
        in_imm = 64'(idx) - 64'd2;
        model(1'b0, in_base, in_imm, 5'd9);
        idx++;
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++;
    if (cyc != 5) begin
      n_fail++; $display("FAIL b2b_cycles: took %0d cycles, required 5", cyc);
    end
    q.delete();
  endtask

  task automatic test_random;
    logic [63:0] imm;
    logic [31:0] base;
    logic [4:0]  rd;
    logic        br, rdv;
    for (int n = 0; n < 12; n++) begin
      imm  = {$urandom, $urandom} >> $urandom_range(0, 60);
      if ($urandom_range(0, 1) == 1) imm = ~imm;
      base = $urandom;
      rd   = 5'($urandom_range(0, 31));
      br   = 1'($urandom_range(0, 1));
      rdv  = 1'($urandom_range(0, 1));
      model(br, base, imm, rdv ? rd : 5'd9);
      issue(br, base, imm, rd, rdv);
      drain($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset;
    test_d_fit;
    test_movk_seq(0);
    test_cb;
    test_movk_seq(3);
    test_skip_hw;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the sign-extension path. Takes a 64-bit signed immediate and a base LEGv8 instruction word whose immediate field is zero.
- Produces the 32-bit instruction word(s) that encode that immediate.
- If the value fits the field once sign-extended, it inserts it into the D-type (9-bit, bits 20:12) or CB-type (19-bit, bits 23:5) field.
- Otherwise it emits a MOVZ/MOVK sequence that loads the immediate into a scratch register, then the base word. Used by the test-program generator and the instruction-memory loader.

Parameters:
- SCRATCH_DEFAULT, 5'd9, scratch register used when in_rd_valid is low

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_branch  input  1  0 = D-type field (9-bit, bits 20:12); 1 = CB-type field (19-bit, bits 23:5)
- in_base  input  32  base instruction; immediate field bits are ignored and overwritten/cleared
- in_imm  input  64  signed immediate
- in_rd  input  5  scratch register for MOVZ/MOVK
- in_rd_valid  input  1  use in_rd, else SCRATCH_DEFAULT
- out_valid  output  1  out_instr valid
- out_ready  input  1  consumer accepts word
- out_instr  output  32  encoded word
- out_last  output  1  final word of the sequence
- out_err  output  1  CB immediate out of range; word carries a zero field

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state = IDLE; out_valid = 0, out_last = 0, out_err = 0, out_instr = 0; in_ready = 1 on the cycle after reset.
  - Reset mid-sequence drops all remaining words. No partial word is emitted after reset.
- in_ready = 1 only in IDLE with no held output (out_valid = 0, or out_valid & out_ready & out_last this cycle). Accept = in_valid & in_ready. Inputs are captured into internal registers on accept.
- Fit test:
  - D: imm[63:8] all equal imm[8].
  - CB: imm[63:18] all equal imm[18].
- States: IDLE, MOVZ, MOVK, BASE.
  - IDLE, accept, fits: next cycle out_instr = base with field = imm[8:0] (D) or imm[18:0] (CB); out_last = 1; out_err = 0; stay IDLE. Latency 1 cycle.
  - IDLE, accept, CB, no fit: next cycle base with bits 23:5 = 0; out_last = 1; out_err = 1; stay IDLE.
  - IDLE, accept, D, no fit: go to MOVZ.
  - MOVZ: emit {9'b110100101, 2'b00, imm[15:0], rd}.
  - MOVK: emit one {9'b111100101, hw[1:0], imm[16*hw+15:16*hw], rd} for each hw in 1..3 with a nonzero halfword, ascending order. Zero halfwords are skipped with no bubble.
  - BASE: emit base with bits 20:12 = 0; out_last = 1; return to IDLE.
  - Sequence length is 2–5 words. out_err = 0 throughout.
- Output register:
  - Advances only when out_valid & out_ready. When out_valid & !out_ready, out_instr, out_last and out_err hold stable.
  - Back-to-back sustain: out_ready held 1 gives one word per cycle. A new request may be accepted in the same cycle its predecessor's last word is consumed.
- Non-immediate bits of base (opcode, Rn, Rt) pass unchanged. The rd selection is captured at accept.

Test Plan:
1. D, base = 0xF8400000, imm = 0xFFFFFFFFFFFFFFFD, out_ready = 1 -> one cycle later out_instr = 0xF85FD000, out_last = 1, out_err = 0; in_ready stays 1.
2. D, base = 0xF8400000, imm = 0x0000000100000005, rd = 9 -> words 0xD28000A9, 0xF2C00029, 0xF8400000 on consecutive cycles; out_last only on the third; in_ready = 0 until the third is consumed.
3. CB, base = 0xB4000000, imm = 0xFFFFFFFFFFFFFFFF -> 0xB4FFFFE0, out_last = 1, out_err = 0. Then imm = 0x40000 -> 0xB4000000, out_err = 1.
4. Case 2 with out_ready low for 3 cycles on the first word -> 0xD28000A9 held stable for all 4 cycles; the sequence then completes with no loss or duplication.
5. D, imm = 0x8000000000000000, in_rd_valid = 0 -> 0xD2800009, 0xF2F00009, base. Halfwords 1 and 2 are skipped.
6. rst asserted on the cycle after the MOVZ word is consumed in case 2 -> out_valid = 0 the next cycle, in_ready = 1, no further words.
